// File: rtl/bf16_pkg.sv
// Shared bfloat16 types and constants.
package bf16_pkg;

   typedef struct packed {
      logic       s;
      logic [7:0] e;
      logic [6:0] m;
   } bf16_t;

   localparam int         EXP_BIAS = 127;
   localparam logic [7:0] EXP_MAX  = 8'hFF;
   localparam bf16_t      QNAN     = {1'b0, 8'hFF, 7'h40};

   function automatic logic is_nan(bf16_t x);
      return (x.e == EXP_MAX) && (x.m != 7'd0);
   endfunction

   function automatic logic is_inf(bf16_t x);
      return (x.e == EXP_MAX) && (x.m == 7'd0);
   endfunction

endpackage

// File: rtl/bf16_lzc.sv
// Combinational leading-zero counter; all-zero input returns W.
module bf16_lzc #(
   parameter int W = 11,
   localparam int CW = $clog2(W + 1)
) (
   input  logic [W-1:0]  d_i,
   output logic [CW-1:0] cnt_o
);

   always_comb begin
      cnt_o = CW'(W);
      for (int i = 0; i < W; i++) begin
         if (d_i[i]) cnt_o = CW'(W - 1 - i);
      end
   end

endmodule

// File: rtl/bf16_add.sv
// bfloat16 adder, RNE, DAZ/FTZ, registered output.
// Define BF16_ADD_IN_REG_EN to also register the operands.
module bf16_add
   import bf16_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       sa_i,
   input  logic [7:0] ea_i,
   input  logic [6:0] ma_i,
   input  logic       sb_i,
   input  logic [7:0] eb_i,
   input  logic [6:0] mb_i,
   output logic       s_o,
   output logic [7:0] e_o,
   output logic [6:0] m_o
);

   bf16_t a, b, big, sml, res_d, res_q;

`ifdef BF16_ADD_IN_REG_EN
   bf16_t a_q, b_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_q <= '0;
         b_q <= '0;
      end else begin
         a_q <= {sa_i, ea_i, ma_i};
         b_q <= {sb_i, eb_i, mb_i};
      end
   end

   assign a = a_q;
   assign b = b_q;
`else
   assign a = {sa_i, ea_i, ma_i};
   assign b = {sb_i, eb_i, mb_i};
`endif

   logic              a_z, b_z, swap, eff_sub, rup;
   logic [7:0]        d;
   logic [10:0]       bx, sx, nrm;
   logic [21:0]       sh;
   logic [11:0]       sum;
   logic [3:0]        lz;
   logic [7:0]        rnd;
   logic signed [9:0] ex, ex_r;

   assign a_z     = (a.e == 8'h00);
   assign b_z     = (b.e == 8'h00);
   assign swap    = {b.e, b.m} > {a.e, a.m};
   assign big     = swap ? b : a;
   assign sml     = swap ? a : b;
   assign eff_sub = big.s ^ sml.s;
   assign d       = big.e - sml.e;
   assign bx      = {1'b1, big.m, 3'b000};
   assign sh      = {1'b1, sml.m, 3'b000, 11'd0} >> d;

   // Bits shifted past the round position fold into sticky
   always_comb begin
      if (d >= 8'd10) sx = 11'd1;
      else            sx = {sh[21:12], sh[11] | (|sh[10:0])};
   end

   assign sum = eff_sub ? ({1'b0, bx} - {1'b0, sx})
                        : ({1'b0, bx} + {1'b0, sx});

   bf16_lzc #(.W(11)) u_lzc (
      .d_i  (sum[10:0]),
      .cnt_o(lz)
   );

   always_comb begin
      if (sum[11]) begin
         nrm = {sum[11:2], sum[1] | sum[0]};
         ex  = $signed({2'b00, big.e}) + 10'sd1;
      end else begin
         nrm = sum[10:0] << lz;
         ex  = $signed({2'b00, big.e}) - $signed({6'd0, lz});
      end
      rup  = nrm[2] & (nrm[1] | nrm[0] | nrm[3]);
      rnd  = {1'b0, nrm[9:3]} + {7'd0, rup};
      ex_r = rnd[7] ? ex + 10'sd1 : ex;
   end

   always_comb begin
      res_d = '0;
      if (is_nan(a) || is_nan(b) || (is_inf(a) && is_inf(b) && eff_sub))
         res_d = QNAN;
      else if (is_inf(a))
         res_d = a;
      else if (is_inf(b))
         res_d = b;
      else if (a_z && b_z)
         res_d = {a.s & b.s, 8'h00, 7'h00};
      else if (a_z)
         res_d = b;
      else if (b_z)
         res_d = a;
      else if (sum == 12'd0)
         res_d = '0;
      else if (ex_r >= 10'sd255)
         res_d = {big.s, EXP_MAX, 7'h00};
      else if (ex_r <= 10'sd0)
         res_d = {big.s, 8'h00, 7'h00};
      else
         res_d = {big.s, ex_r[7:0], rnd[6:0]};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) res_q <= '0;
      else     res_q <= res_d;
   end

   assign s_o = res_q.s;
   assign e_o = res_q.e;
   assign m_o = res_q.m;

endmodule

// File: tb/tb_bf16_add.sv
// Self-checking bench for bf16_add: vector table, scoreboard, reset sequence.
module tb_bf16_add;
   import bf16_pkg::*;

`ifdef BF16_ADD_IN_REG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       sa, sb, s_o;
   logic [7:0] ea, eb, e_o;
   logic [6:0] ma, mb, m_o;

   bf16_add dut (
      .clk (clk),
      .rst (rst),
      .sa_i(sa),
      .ea_i(ea),
      .ma_i(ma),
      .sb_i(sb),
      .eb_i(eb),
      .mb_i(mb),
      .s_o (s_o),
      .e_o (e_o),
      .m_o (m_o)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] r;
   } vec_t;

   typedef struct {
      logic [15:0] r;
      int          id;
      int          due;
   } exp_t;

   localparam int NV = 25;
   vec_t vt[NV];
   exp_t scb[$];
   int   checks = 0;
   int   fails = 0;

   task automatic chk(input string nm, input int id, input logic [15:0] want);
      checks++;
      if ({s_o, e_o, m_o} !== want) begin
         fails++;
         $display("FAIL %s%0d got %04h want %04h", nm, id, {s_o, e_o, m_o}, want);
      end
   endtask

   task automatic drain();
      exp_t x;
      if (scb.size() > 0 && scb[0].due <= cyc) begin
         x = scb.pop_front();
         chk("vec", x.id, x.r);
      end
   endtask

   initial begin
      vt[0]  = '{16'h0000, 16'h0000, 16'h0000};
      vt[1]  = '{16'h0000, 16'h8000, 16'h0000};
      vt[2]  = '{16'h8000, 16'h8000, 16'h8000};
      vt[3]  = '{16'h0000, 16'h3F80, 16'h3F80};
      vt[4]  = '{16'h8000, 16'h3F80, 16'h3F80};
      vt[5]  = '{16'h3F80, 16'h3F80, 16'h4000};
      vt[6]  = '{16'h3F80, 16'hBF80, 16'h0000};
      vt[7]  = '{16'h3F80, 16'h3B80, 16'h3F80};
      vt[8]  = '{16'h3F80, 16'h3BC0, 16'h3F81};
      vt[9]  = '{16'h7F7F, 16'h7F7F, 16'h7F80};
      vt[10] = '{16'h7F80, 16'hFF80, 16'h7FC0};
      vt[11] = '{16'h7F81, 16'h3F80, 16'h7FC0};
      vt[12] = '{16'h7F80, 16'h3F80, 16'h7F80};
      vt[13] = '{16'hFF80, 16'hFF80, 16'hFF80};
      vt[14] = '{16'h0055, 16'h3FC0, 16'h3FC0};
      vt[15] = '{16'h3F80, 16'hBFC0, 16'hBF00};
      vt[16] = '{16'h0080, 16'h8081, 16'h8000};
      vt[17] = '{16'h3F80, 16'h3F81, 16'h4000};
      vt[18] = '{16'h3F80, 16'h3F83, 16'h4002};
      vt[19] = '{16'h7F7F, 16'h3F80, 16'h7F7F};
      vt[20] = '{16'h3F80, 16'h3580, 16'h3F80};
      vt[21] = '{16'hBF80, 16'h3F00, 16'hBF00};
      vt[22] = '{16'h3FFF, 16'h3BC0, 16'h4000};
      vt[23] = '{16'h7F7F, 16'h7B40, 16'h7F80};
      vt[24] = '{16'h3F00, 16'hBF80, 16'hBF00};

      {sa, ea, ma} = 16'h3F80;
      {sb, eb, mb} = 16'h4000;
      #3;
      chk("rst_init", 0, 16'h0000);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < NV; i++) begin
         @(negedge clk);
         drain();
         {sa, ea, ma} = vt[i].a;
         {sb, eb, mb} = vt[i].b;
         scb.push_back('{vt[i].r, i, cyc + LAT});
      end
      for (int k = 0; k < LAT + 4 && scb.size() > 0; k++) begin
         @(negedge clk);
         drain();
      end
      if (scb.size() > 0) begin
         checks++;
         fails++;
         $display("FAIL timeout got %0d pending want 0", scb.size());
      end

      @(negedge clk);
      {sa, ea, ma} = 16'h3F80;
      {sb, eb, mb} = 16'h3F80;
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("rst_async", 0, 16'h0000);
      @(posedge clk);
      #1;
      chk("rst_held", 0, 16'h0000);
      @(negedge clk);
      rst = 1'b0;
      repeat (LAT) @(posedge clk);
      #1;
      chk("rst_recover", 0, 16'h4000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
